e_muldiv_unit: RTL and testbench
================================

Name: e_muldiv_unit

Overview:
- Execute-stage multiply/divide unit with HI/LO registers.
- Consumes the instruction fields and operand values held by the D->E pipeline register. Drives busy back to the stall controller, which deasserts that register's write enable while an operation is in flight.
- mult/multu/div/divu run as multi-cycle operations.
- mthi/mtlo are single-cycle writes.
- hi/lo feed mfhi/mflo through the E-stage result mux.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1)
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  E-stage instruction is a muldiv op; qualifies op
- op  input  3  operation code (package constants)
- rs  input  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source)
- rt  input  32  forwarded rt operand (divisor / multiplier)
- busy  output  1  operation in flight; stall controller treats (start | busy) as stall source for muldiv/mf/mt instructions in D
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset is synchronous and active-high; clk is the clock. On reset:
  - busy=0, hi=0, lo=0, counter=0, latched operands=0.
  - Reset mid-operation aborts the operation; no HI/LO write follows.
- States: IDLE (busy=0), RUN (busy=1). A down-counter of width clog2(DIV_CYCLES+1) is held in a register.
- IDLE, edge with start=1 and op in {MULT,MULTU,DIV,DIVU}:
  - Latch op/rs/rt.
  - counter <= MULT_CYCLES or DIV_CYCLES.
  - busy <= 1; go to RUN.
- IDLE, edge with start=1 and op=MTHI: hi <= rs; busy stays 0. op=MTLO: lo <= rs likewise.
- IDLE, start=1 with op=NONE or an undefined code: no state change.
- RUN, each edge: counter <= counter-1. On the edge where counter==1:
  - hi/lo <= result.
  - busy <= 0; go to IDLE.
- Timing: start sampled at edge T gives busy high for exactly N cycles (edges T..T+N-1 latched). New hi/lo are visible after edge T+N, in the same cycle busy falls.
- Operand latching: result uses the operands latched at start, so later changes on rs/rt during RUN have no effect.
- Any start (including MTHI/MTLO) while busy=1 is ignored. The stall controller prevents it; the unit must not corrupt state if it occurs.
- mult: {hi,lo} = signed(rs)*signed(rt), 64-bit.
- multu: {hi,lo} = unsigned 64-bit product.
- div:
  - lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned quotient in lo, remainder in hi.
- Divide by zero (rt=0) for div/divu: full DIV_CYCLES busy, then hi/lo unchanged.
- Results are computed combinationally from the latched operands and committed only at completion; intermediate cycles never alter hi/lo.

Decomposition:
- Shared const package:
  - MD_NONE=3'd0, MD_MULT=3'd1, MD_MULTU=3'd2, MD_DIV=3'd3, MD_DIVU=3'd4, MD_MTHI=3'd5, MD_MTLO=3'd6.
  - Default cycle counts.
- One sub-module md_arith, combinational.
  - Inputs: latched op, a, b.
  - Outputs: res_hi, res_lo, res_valid (0 for divide-by-zero or non-arith op).
  - Holds all signed/unsigned, truncation and overflow-case handling.
- e_muldiv_unit keeps only the FSM, counter, operand latches and HI/LO registers.

Test Plan:
- Reset, then start=1 op=MULT rs=0xFFFFFFFE rt=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0 the same cycle.
- start op=MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF, then DIV rs=0xFFFFFFF9 (-7) rt=2:
  - MULTU -> hi=0xFFFFFFFE, lo=0x00000001.
  - DIV -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- MTHI rs=0x1234, next cycle MTLO rs=0x5678 -> busy never asserts; hi=0x1234 after first edge, lo=0x5678 after second.
- DIVU rs=5 rt=0 after hi=0xA, lo=0xB preset -> busy 10 cycles, hi=0xA, lo=0xB unchanged. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start MULT, on cycle 2 of RUN assert start MTLO rs=0xDEAD and change rs/rt -> MTLO ignored; final hi/lo match the originally latched operands.
- Start DIV, assert reset at cycle 4 of RUN -> next cycle busy=0, hi=lo=0; no write at the original completion cycle.

Source files
------------

// File: rtl/e_muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : e_muldiv_unit_pkg
//  Description : Operation codes and default latencies for the E-stage
//                multiply/divide unit.
//  Revision    : 1.0  initial release
// ============================================================================
package e_muldiv_unit_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam int MULT_CYCLES_DEFAULT = 5;
    localparam int DIV_CYCLES_DEFAULT  = 10;

endpackage
`default_nettype wire

// File: rtl/e_muldiv_unit_md_arith.sv
`default_nettype none
// ============================================================================
//  Module      : md_arith
//  Description : Combinational multiply/divide datapath producing HI/LO.
//  Revision    : 1.0  initial release
// ============================================================================
module md_arith
    import e_muldiv_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        res_valid
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_is_sdiv;
    logic        w_b_zero;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_den;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q;
    logic [31:0] w_r;

    assign w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign w_prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide runs on magnitudes; 0x80000000 / -1 falls out naturally
    // because the magnitude 0x80000000 is representable unsigned.
    assign w_is_sdiv = (op == MD_DIV);
    assign w_b_zero  = (b == 32'd0);
    assign w_a_mag   = (w_is_sdiv && a[31]) ? (32'd0 - a) : a;
    assign w_b_mag   = (w_is_sdiv && b[31]) ? (32'd0 - b) : b;
    assign w_den     = w_b_zero ? 32'd1 : w_b_mag;
    assign w_q_mag   = w_a_mag / w_den;
    assign w_r_mag   = w_a_mag % w_den;
    assign w_q       = (w_is_sdiv && (a[31] ^ b[31])) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_r       = (w_is_sdiv && a[31]) ? (32'd0 - w_r_mag) : w_r_mag;

    always_comb begin
        res_hi    = 32'd0;
        res_lo    = 32'd0;
        res_valid = 1'b0;
        case (op)
            MD_MULT: begin
                {res_hi, res_lo} = w_prod_s;
                res_valid        = 1'b1;
            end
            MD_MULTU: begin
                {res_hi, res_lo} = w_prod_u;
                res_valid        = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
                res_hi    = w_r;
                res_lo    = w_q;
                res_valid = !w_b_zero;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/e_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : e_muldiv_unit
//  Description : Execute-stage multi-cycle multiply/divide unit with HI/LO.
//  Revision    : 1.0  initial release
// ============================================================================
module e_muldiv_unit
    import e_muldiv_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_cw         = $clog2(c_max_cycles + 1);

    localparam logic [c_cw-1:0] c_mult_cnt = c_cw'(MULT_CYCLES);
    localparam logic [c_cw-1:0] c_div_cnt  = c_cw'(DIV_CYCLES);
    localparam logic [c_cw-1:0] c_cnt_one  = c_cw'(1);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    logic [0:0]      r_state;
    logic [c_cw-1:0] r_count;
    logic [2:0]      r_op;
    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic [31:0]     r_hi;
    logic [31:0]     r_lo;

    logic [31:0]     w_res_hi;
    logic [31:0]     w_res_lo;
    logic            w_res_valid;

    md_arith u_arith (
        .op        (r_op),
        .a         (r_a),
        .b         (r_b),
        .res_hi    (w_res_hi),
        .res_lo    (w_res_lo),
        .res_valid (w_res_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_count <= '0;
            r_op    <= MD_NONE;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        case (op)
                            MD_MULT, MD_MULTU: begin
                                r_op    <= op;
                                r_a     <= rs;
                                r_b     <= rt;
                                r_count <= c_mult_cnt;
                                r_state <= c_st_run;
                            end
                            MD_DIV, MD_DIVU: begin
                                r_op    <= op;
                                r_a     <= rs;
                                r_b     <= rt;
                                r_count <= c_div_cnt;
                                r_state <= c_st_run;
                            end
                            MD_MTHI: r_hi <= rs;
                            MD_MTLO: r_lo <= rs;
                            default: ;
                        endcase
                    end
                end
                default: begin
                    // Any start arriving while running is dropped on purpose.
                    r_count <= r_count - c_cnt_one;
                    if (r_count == c_cnt_one) begin
                        if (w_res_valid) begin
                            r_hi <= w_res_hi;
                            r_lo <= w_res_lo;
                        end
                        r_state <= c_st_idle;
                    end
                end
            endcase
        end
    end

    assign busy = (r_state == c_st_run);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_e_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_e_muldiv_unit
//  Description : Directed self-checking bench for e_muldiv_unit with an
//                arithmetic reference model compared every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_e_muldiv_unit;
    import e_muldiv_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors    = 0;
    int miscompares = 0;
    bit chk_en     = 0;

    e_muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .rs    (rs),
        .rt    (rt),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: tracks remaining busy edges and the pending result.
    bit          m_busy;
    int          m_left;
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    bit          m_pvalid;

    always @(posedge clk) begin
        longint sa, sb;
        logic [63:0] p;
        if (reset) begin
            m_busy = 0; m_left = 0; m_hi = 0; m_lo = 0; m_pvalid = 0;
        end else if (m_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_busy = 0;
                if (m_pvalid) begin m_hi = m_phi; m_lo = m_plo; end
            end
        end else if (start) begin
            case (op)
                MD_MULT: begin
                    sa = longint'($signed(rs)); sb = longint'($signed(rt));
                    p = 64'(sa * sb);
                    {m_phi, m_plo} = p; m_pvalid = 1; m_busy = 1; m_left = 5;
                end
                MD_MULTU: begin
                    p = {32'd0, rs} * {32'd0, rt};
                    {m_phi, m_plo} = p; m_pvalid = 1; m_busy = 1; m_left = 5;
                end
                MD_DIV: begin
                    sa = longint'($signed(rs)); sb = longint'($signed(rt));
                    m_pvalid = (rt != 0);
                    if (m_pvalid) begin
                        m_plo = 32'(sa / sb); m_phi = 32'(sa % sb);
                    end
                    m_busy = 1; m_left = 10;
                end
                MD_DIVU: begin
                    m_pvalid = (rt != 0);
                    if (m_pvalid) begin m_plo = rs / rt; m_phi = rs % rt; end
                    m_busy = 1; m_left = 10;
                end
                MD_MTHI: m_hi = rs;
                MD_MTLO: m_lo = rs;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (busy !== m_busy || hi !== m_hi || lo !== m_lo) begin
                miscompares++;
                $display("FAIL model t=%0t busy=%b hi=%h lo=%h required busy=%b hi=%h lo=%h",
                         $time, busy, hi, lo, m_busy, m_hi, m_lo);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; rs = a; rt = b;
        @(negedge clk);
        start = 1'b0; op = MD_NONE;
    endtask

    // Counts the negedges with busy high, bounded so a stuck unit still ends.
    task automatic run_count(output int n);
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            vectors++; miscompares++;
            $display("FAIL busy_timeout actual=%0d required=<50", n);
        end
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; op = MD_NONE; rs = 0; rt = 0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        chk_en = 1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        issue(MD_MULT, 32'hFFFFFFFE, 32'd3);
        run_count(n);
        check("mult_cycles", 32'(n), 32'd5);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFA);

        issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_count(n);
        check("multu_hi", hi, 32'hFFFFFFFE);
        check("multu_lo", lo, 32'h00000001);

        issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
        run_count(n);
        check("div_cycles", 32'(n), 32'd10);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);

        @(negedge clk);
        start = 1'b1; op = MD_MTHI; rs = 32'h1234;
        @(negedge clk);
        check("mthi_busy", 32'(busy), 32'd0);
        check("mthi_hi", hi, 32'h1234);
        op = MD_MTLO; rs = 32'h5678;
        @(negedge clk);
        start = 1'b0; op = MD_NONE;
        check("mtlo_busy", 32'(busy), 32'd0);
        check("mtlo_lo", lo, 32'h5678);

        issue(MD_MTHI, 32'hA, 32'd0);
        issue(MD_MTLO, 32'hB, 32'd0);
        issue(MD_DIVU, 32'd5, 32'd0);
        run_count(n);
        check("divu0_cycles", 32'(n), 32'd10);
        check("divu0_hi", hi, 32'hA);
        check("divu0_lo", lo, 32'hB);

        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
        run_count(n);
        check("divovf_lo", lo, 32'h80000000);
        check("divovf_hi", hi, 32'h0);

        issue(MD_DIVU, 32'd100, 32'd7);
        run_count(n);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        issue(MD_NONE, 32'h5555, 32'h1);
        issue(3'd7, 32'h6666, 32'h1);
        check("undef_busy", 32'(busy), 32'd0);
        check("undef_hi", hi, 32'd2);

        issue(MD_MULT, 32'd7, 32'd6);
        @(negedge clk);
        start = 1'b1; op = MD_MTLO; rs = 32'hDEAD; rt = 32'd99;
        @(negedge clk);
        start = 1'b0; op = MD_NONE; rs = 32'h1111; rt = 32'h2222;
        run_count(n);
        check("ignore_hi", hi, 32'd0);
        check("ignore_lo", lo, 32'd42);

        issue(MD_DIV, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        repeat (12) @(negedge clk);
        check("abort_late_hi", hi, 32'd0);
        check("abort_late_lo", lo, 32'd0);

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
